// File: rtl/scr1_tcm_pkg.sv
// Shared definitions for the SCR1 TCM array.
//   SCR1_TCM_RD_LAT_MIN/MAX : legal read latency bounds
//   scr1_byte_merge          : per-lane merge of a written word into an old word
//   scr1_byte_parity         : per-lane even-parity bits of a word
// Helpers work on a fixed maximum width; callers zero-extend and slice.
package scr1_tcm_pkg;

    localparam int unsigned SCR1_TCM_RD_LAT_MIN  = 1;
    localparam int unsigned SCR1_TCM_RD_LAT_MAX  = 2;
    localparam int unsigned SCR1_TCM_MAX_WIDTH   = 128;
    localparam int unsigned SCR1_TCM_MAX_NBYTES  = SCR1_TCM_MAX_WIDTH / 8;

    typedef logic [SCR1_TCM_MAX_WIDTH-1:0]  scr1_tcm_word_t;
    typedef logic [SCR1_TCM_MAX_NBYTES-1:0] scr1_tcm_be_t;

    function automatic scr1_tcm_word_t scr1_byte_merge(input scr1_tcm_word_t old_word,
                                                       input scr1_tcm_word_t new_word,
                                                       input scr1_tcm_be_t   be);
        scr1_tcm_word_t res;
        res = old_word;
        for (int i = 0; i < int'(SCR1_TCM_MAX_NBYTES); i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    // Even parity: the stored bit makes each 9-bit lane have an even number of ones.
    function automatic scr1_tcm_be_t scr1_byte_parity(input scr1_tcm_word_t word);
        scr1_tcm_be_t par;
        for (int i = 0; i < int'(SCR1_TCM_MAX_NBYTES); i++) begin
            par[i] = ^word[8*i +: 8];
        end
        return par;
    endfunction

endpackage

// File: rtl/scr1_dp_memory_pl_if.sv
// Bus bundle between the TCM router (master) and the dual-port array (slave).
//   Port A: rena, addra -> qa, qa_vld            (read-only)
//   Port B: renb, wenb, webb, addrb, datab -> qb, qb_vld
//   With SCR1_TCM_PARITY_EN defined, qa_perr/qb_perr are added.
interface scr1_dp_memory_pl_if #(
    parameter int unsigned SCR1_WIDTH  = 32,
    parameter int unsigned SCR1_NBYTES = SCR1_WIDTH / 8,
    parameter int unsigned SCR1_AWIDTH = 14
);
    logic                   rena;
    logic [SCR1_AWIDTH-1:0] addra;
    logic [SCR1_WIDTH-1:0]  qa;
    logic                   qa_vld;
    logic                   renb;
    logic                   wenb;
    logic [SCR1_NBYTES-1:0] webb;
    logic [SCR1_AWIDTH-1:0] addrb;
    logic [SCR1_WIDTH-1:0]  datab;
    logic [SCR1_WIDTH-1:0]  qb;
    logic                   qb_vld;
`ifdef SCR1_TCM_PARITY_EN
    logic                   qa_perr;
    logic                   qb_perr;

    modport master (output rena, addra, renb, wenb, webb, addrb, datab,
                    input  qa, qa_vld, qb, qb_vld, qa_perr, qb_perr);
    modport slave  (input  rena, addra, renb, wenb, webb, addrb, datab,
                    output qa, qa_vld, qb, qb_vld, qa_perr, qb_perr);
`else
    modport master (output rena, addra, renb, wenb, webb, addrb, datab,
                    input  qa, qa_vld, qb, qb_vld);
    modport slave  (input  rena, addra, renb, wenb, webb, addrb, datab,
                    output qa, qa_vld, qb, qb_vld);
`endif
endinterface

// File: rtl/scr1_mem_rd_pipe.sv
// Read-side output register plus valid pipeline, SCR1_RD_LAT stages deep.
//   clk, rst_n : clock, synchronous active-low reset (clears every stage)
//   req_vld    : read accepted at the array this cycle
//   req_data   : array-stage word (already forwarded)
//   rsp_vld    : one-cycle valid pulse at the output
//   rsp_data   : output data, held between responses
module scr1_mem_rd_pipe #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SCR1_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_vld,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_vld,
    output logic [DATA_W-1:0] rsp_data
);
    logic [SCR1_RD_LAT-1:0] vld_q;
    logic [DATA_W-1:0]      data_q [SCR1_RD_LAT];

    // Data stages load only behind a valid; valid stages shift every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < int'(SCR1_RD_LAT); i++) data_q[i] <= '0;
        end else begin
            vld_q[0] <= req_vld;
            if (req_vld) data_q[0] <= req_data;
            for (int i = 1; i < int'(SCR1_RD_LAT); i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end

    assign rsp_vld  = vld_q[SCR1_RD_LAT-1];
    assign rsp_data = data_q[SCR1_RD_LAT-1];

endmodule

// File: rtl/scr1_dp_memory_pl.sv
// Dual-port TCM array with selectable read latency and write-first forwarding.
//   clk, rst_n : clock, synchronous active-low reset (array contents are not reset)
//   bus        : slave side of scr1_dp_memory_pl_if (port A read, port B read/write)
// Optional macro SCR1_TCM_PARITY_EN adds one even-parity bit per byte and
// qa_perr/qb_perr error flags aligned with the valid strobes.
module scr1_dp_memory_pl
    import scr1_tcm_pkg::*;
#(
    parameter int unsigned SCR1_WIDTH  = 32,
    parameter int unsigned SCR1_SIZE   = 32'h00010000,
    parameter int unsigned SCR1_NBYTES = SCR1_WIDTH / 8,
    parameter int unsigned SCR1_RD_LAT = 1
) (
    input logic                clk,
    input logic                rst_n,
    scr1_dp_memory_pl_if.slave bus
);
    localparam int unsigned DEPTH = SCR1_SIZE / SCR1_NBYTES;
`ifdef SCR1_TCM_PARITY_EN
    localparam int unsigned PIPE_W = SCR1_WIDTH + 1;
`else
    localparam int unsigned PIPE_W = SCR1_WIDTH;
`endif

    if (SCR1_RD_LAT < SCR1_TCM_RD_LAT_MIN || SCR1_RD_LAT > SCR1_TCM_RD_LAT_MAX) begin : g_lat_chk
        $error("SCR1_RD_LAT must be 1 or 2");
    end

    logic [SCR1_WIDTH-1:0]  mem_data [DEPTH];
    logic [SCR1_WIDTH-1:0]  rda_word, rdb_word, mrga_word, mrgb_word;
    logic [SCR1_NBYTES-1:0] fwda_be, fwdb_be;
    scr1_tcm_word_t         mrga_ext, mrgb_ext;
    logic [PIPE_W-1:0]      pipe_a_in, pipe_a_out, pipe_b_in, pipe_b_out;
    logic                   vld_a, vld_b;

    assign rda_word = mem_data[bus.addra];
    assign rdb_word = mem_data[bus.addrb];

    // Collision lanes are muxed from the write bus, independent of RAM read-during-write.
    assign fwda_be = (bus.wenb && (bus.addra == bus.addrb)) ? bus.webb : '0;
    assign fwdb_be = bus.wenb ? bus.webb : '0;

    assign mrga_ext  = scr1_byte_merge(scr1_tcm_word_t'(rda_word), scr1_tcm_word_t'(bus.datab),
                                       scr1_tcm_be_t'(fwda_be));
    assign mrgb_ext  = scr1_byte_merge(scr1_tcm_word_t'(rdb_word), scr1_tcm_word_t'(bus.datab),
                                       scr1_tcm_be_t'(fwdb_be));
    assign mrga_word = mrga_ext[SCR1_WIDTH-1:0];
    assign mrgb_word = mrgb_ext[SCR1_WIDTH-1:0];

    // Array writes ignore reset on purpose.
    always_ff @(posedge clk) begin
        if (bus.wenb) begin
            for (int i = 0; i < int'(SCR1_NBYTES); i++) begin
                if (bus.webb[i]) mem_data[bus.addrb][8*i +: 8] <= bus.datab[8*i +: 8];
            end
        end
    end

    if (SCR1_WIDTH < SCR1_TCM_MAX_WIDTH) begin : g_hi_unused
        logic unused_hi;
        assign unused_hi = ^{mrga_ext[SCR1_TCM_MAX_WIDTH-1:SCR1_WIDTH],
                             mrgb_ext[SCR1_TCM_MAX_WIDTH-1:SCR1_WIDTH]};
    end

`ifdef SCR1_TCM_PARITY_EN
    logic [SCR1_NBYTES-1:0] mem_par [DEPTH];
    scr1_tcm_be_t           par_wr_ext, par_a_ext, par_b_ext;
    logic [SCR1_NBYTES-1:0] par_wr, eff_a, eff_b;
    logic                   perr_a, perr_b;

    assign par_wr_ext = scr1_byte_parity(scr1_tcm_word_t'(bus.datab));
    assign par_a_ext  = scr1_byte_parity(mrga_ext);
    assign par_b_ext  = scr1_byte_parity(mrgb_ext);
    assign par_wr     = par_wr_ext[SCR1_NBYTES-1:0];

    always_ff @(posedge clk) begin
        if (bus.wenb) begin
            for (int i = 0; i < int'(SCR1_NBYTES); i++) begin
                if (bus.webb[i]) mem_par[bus.addrb][i] <= par_wr[i];
            end
        end
    end

    // Forwarded lanes take fresh parity, so they can never mismatch.
    assign eff_a  = (mem_par[bus.addra] & ~fwda_be) | (par_wr & fwda_be);
    assign eff_b  = (mem_par[bus.addrb] & ~fwdb_be) | (par_wr & fwdb_be);
    assign perr_a = |(eff_a ^ par_a_ext[SCR1_NBYTES-1:0]);
    assign perr_b = |(eff_b ^ par_b_ext[SCR1_NBYTES-1:0]);

    if (SCR1_NBYTES < SCR1_TCM_MAX_NBYTES) begin : g_par_unused
        logic unused_par;
        assign unused_par = ^{par_wr_ext[SCR1_TCM_MAX_NBYTES-1:SCR1_NBYTES],
                              par_a_ext[SCR1_TCM_MAX_NBYTES-1:SCR1_NBYTES],
                              par_b_ext[SCR1_TCM_MAX_NBYTES-1:SCR1_NBYTES]};
    end

    assign pipe_a_in   = {perr_a, mrga_word};
    assign pipe_b_in   = {perr_b, mrgb_word};
    assign bus.qa      = pipe_a_out[SCR1_WIDTH-1:0];
    assign bus.qb      = pipe_b_out[SCR1_WIDTH-1:0];
    assign bus.qa_perr = pipe_a_out[SCR1_WIDTH];
    assign bus.qb_perr = pipe_b_out[SCR1_WIDTH];
`else
    assign pipe_a_in = mrga_word;
    assign pipe_b_in = mrgb_word;
    assign bus.qa    = pipe_a_out;
    assign bus.qb    = pipe_b_out;
`endif

    assign bus.qa_vld = vld_a;
    assign bus.qb_vld = vld_b;

    scr1_mem_rd_pipe #(
        .DATA_W      (PIPE_W),
        .SCR1_RD_LAT (SCR1_RD_LAT)
    ) u_pipe_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_vld  (bus.rena),
        .req_data (pipe_a_in),
        .rsp_vld  (vld_a),
        .rsp_data (pipe_a_out)
    );

    scr1_mem_rd_pipe #(
        .DATA_W      (PIPE_W),
        .SCR1_RD_LAT (SCR1_RD_LAT)
    ) u_pipe_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_vld  (bus.renb),
        .req_data (pipe_b_in),
        .rsp_vld  (vld_b),
        .rsp_data (pipe_b_out)
    );

endmodule
